fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word addresses to a one-cycle-latency instruction memory,
// presents fetched words behind a one-entry skid buffer, and handles redirects and end-of-memory.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH = 30,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] retired_cnt
);

    localparam logic [31:0] DepthW   = 32'(MEM_DEPTH);
    localparam logic [31:0] ResetPcW = 32'(RESET_PC);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        halted_q, halted_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] retired_cnt_q, retired_cnt_d;

    logic issue;
    logic accept;

    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        pend_d        = 1'b0;
        pend_pc_d     = pend_pc_q;
        skid_v_d      = skid_v_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_err_d   = fetch_err_q;
        retired_cnt_d = retired_cnt_q;

        accept = if_valid_q && !stall;
        issue  = (state_q == StFetch) && (fpc_q < DepthW) && !skid_v_q
                 && !(stall && if_valid_q && pend_q) && !redirect_valid;

        if (redirect_valid) begin
            // Flush everything in flight; the flushed output word is never counted.
            if_valid_d = 1'b0;
            skid_v_d   = 1'b0;
            fpc_d      = redirect_pc;
            if (redirect_pc >= DepthW) begin
                fetch_err_d = 1'b1;
                state_d     = StDrain;
            end else begin
                state_d = StFetch;
            end
        end else begin
            if (issue) begin
                fpc_d     = fpc_q + 32'd1;
                pend_d    = 1'b1;
                pend_pc_d = fpc_q;
            end

            if (stall && if_valid_q && pend_q) begin
                skid_v_d     = 1'b1;
                skid_instr_d = imem_instr;
                skid_pc_d    = pend_pc_q;
            end

            if (!if_valid_q || !stall) begin
                if (skid_v_q) begin
                    if_valid_d = 1'b1;
                    if_instr_d = skid_instr_q;
                    if_pc_d    = skid_pc_q;
                    skid_v_d   = 1'b0;
                end else if (pend_q) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem_instr;
                    if_pc_d    = pend_pc_q;
                end else begin
                    if_valid_d = 1'b0;
                end
            end

            if (accept && (retired_cnt_q != 16'hFFFF)) begin
                retired_cnt_d = retired_cnt_q + 16'd1;
            end

            case (state_q)
                StFetch: if (fpc_q >= DepthW) state_d = StDrain;
                StDrain: if (!pend_q && !skid_v_q && !if_valid_q) state_d = StHalt;
                StHalt:  state_d = StHalt;
                default: state_d = StFetch;
            endcase
        end

        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            fpc_q         <= ResetPcW;
            pend_q        <= 1'b0;
            pend_pc_q     <= 32'd0;
            skid_v_q      <= 1'b0;
            skid_instr_q  <= 32'd0;
            skid_pc_q     <= 32'd0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'd0;
            if_pc_q       <= 32'd0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
            retired_cnt_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            skid_v_q      <= skid_v_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            halted_q      <= halted_d;
            fetch_err_q   <= fetch_err_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign imem_addr   = fpc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;
    assign retired_cnt = retired_cnt_q;

endmodule
